// File: rtl/oled_pkg.sv
// oled_pkg: SSD1306 constants and the I2C write engine state encoding
package oled_pkg;
  localparam logic [7:0] OLED_SLAVE_ADDR = 8'h78;
  localparam logic [7:0] OLED_CTRL_CMD = 8'h00;
  localparam logic [7:0] OLED_CTRL_DATA = 8'h40;
  localparam int OLED_XFER_QUARTERS = 116;
  typedef enum logic [2:0] {IDLE, START, BIT, STOP, DONE} oled_state_e;
endpackage

// File: rtl/i2c_quarter_tick.sv
// i2c_quarter_tick: one-cycle tick every CLK_DIV cycles while run is high
// ports: clk, rst_n (sync, active-low), run (count enable, restarts at 0 when low), tick (terminal count)
module i2c_quarter_tick #(
  parameter int CLK_DIV = 125
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);
  logic [15:0] cnt;
  assign tick = run && cnt == 16'(CLK_DIV - 1);
  always_ff @(posedge clk)
    if (!rst_n || !run) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 16'd1;
endmodule

// File: rtl/oled_i2c_wr.sv
// oled_i2c_wr: I2C write engine sending SLAVE_ADDR, reg_addr, reg_data per request
// ports: clk, rst_n (sync, active-low); i2c_wen/reg_addr/reg_data request (latched on acceptance);
//        i2c_done one-cycle end pulse, busy, ack_err sticky NACK; scl push-pull, sda_oe pulls SDA low, sda_i pad input
module oled_i2c_wr
  import oled_pkg::*;
#(
  parameter int CLK_DIV = 125,
  parameter logic [7:0] SLAVE_ADDR = OLED_SLAVE_ADDR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i2c_wen,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_data,
  output logic       i2c_done,
  output logic       busy,
  output logic       ack_err,
  output logic       scl,
  output logic       sda_oe,
  input  logic       sda_i
);
  oled_state_e state, state_n;
  logic [1:0] q, byte_idx;
  logic [3:0] bit_idx;
  logic [7:0] sh, ra, rd;
  logic ack_bit, tick, q_end, ack_slot, scl_c, sda_c;
  assign busy = state inside {START, BIT, STOP};
  assign i2c_done = state == DONE;
  assign q_end = tick && q == 2'd3;
  assign ack_slot = bit_idx == 4'd8;
  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (busy),
    .tick (tick)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (i2c_wen) state_n = START;
      START: if (q_end) state_n = BIT;
      BIT:   if (q_end && ack_slot && (ack_bit || byte_idx == 2'd2)) state_n = STOP;
      STOP:  if (q_end) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  // Pin levels are decoded from the quarter and registered so SCL/SDA never glitch.
  always_comb begin
    scl_c = state == START ? q != 2'd3 : state == BIT ? q[1] : state == STOP ? q != 2'd0 : 1'b1;
    sda_c = state == START ? q != 2'd0 : state == BIT ? !ack_slot && !sh[7] : state == STOP ? !q[1] : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      q        <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      sh       <= '0;
      ra       <= '0;
      rd       <= '0;
      ack_bit  <= 1'b0;
      ack_err  <= 1'b0;
      scl      <= 1'b1;
      sda_oe   <= 1'b0;
    end else begin
      state  <= state_n;
      scl    <= scl_c;
      sda_oe <= sda_c;
      if (state == IDLE && i2c_wen) begin
        ra       <= reg_addr;
        rd       <= reg_data;
        sh       <= SLAVE_ADDR;
        ack_err  <= 1'b0;
        q        <= '0;
        bit_idx  <= '0;
        byte_idx <= '0;
      end
      if (tick) q <= q + 2'd1;
      if (state == BIT && tick && q == 2'd2 && ack_slot) ack_bit <= sda_i;
      if (state == BIT && q_end) begin
        bit_idx <= ack_slot ? 4'd0 : bit_idx + 4'd1;
        if (ack_slot) begin
          byte_idx <= byte_idx + 2'd1;
          sh       <= byte_idx == 2'd0 ? ra : rd;
          if (ack_bit) ack_err <= 1'b1;
        end else sh <= {sh[6:0], 1'b0};
      end
    end
  end
endmodule

// File: tb/tb_oled_i2c_wr.sv
// tb_oled_i2c_wr: directed bench with a bus decoder and ACK/NACK slave model
module tb_oled_i2c_wr;
  import oled_pkg::*;
  localparam int D = 4;
  logic clk = 1'b0, rst_n = 1'b0, i2c_wen = 1'b0;
  logic [7:0] reg_addr = '0, reg_data = '0;
  logic i2c_done, busy, ack_err, scl, sda_oe, sda_i;
  logic slave_pull = 1'b0;
  assign sda_i = ~sda_oe & ~slave_pull;
  always #5 clk = ~clk;
  oled_i2c_wr #(.CLK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .i2c_wen(i2c_wen), .reg_addr(reg_addr), .reg_data(reg_data),
    .i2c_done(i2c_done), .busy(busy), .ack_err(ack_err), .scl(scl), .sda_oe(sda_oe), .sda_i(sda_i)
  );
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  logic ps = 1'b1, pd = 1'b1, bus;
  logic [8:0] sr = '0;
  logic [7:0] got_b [64];
  logic got_a [64];
  int nbits = 0, ndec = 0, nstart = 0, nstop = 0, ndone = 0, nack_at = -1;
  always @(negedge clk) begin
    bus = ~sda_oe & ~slave_pull;
    if (i2c_done) ndone++;
    if (ps && scl && pd && !bus) begin nstart++; nbits = 0; end
    if (ps && scl && !pd && bus) nstop++;
    if (!ps && scl) begin
      sr = {sr[7:0], bus};
      nbits++;
      if (nbits == 9) begin
        got_b[ndec] = sr[8:1];
        got_a[ndec] = sr[0];
        ndec++;
        nbits = 0;
      end
    end
    if (ps && !scl) slave_pull = (nbits == 8) && (ndec != nack_at);
    ps = scl;
    pd = bus;
  end
  task automatic xfer(input string tag, input logic [7:0] a, input logic [7:0] d, input int nack_rel,
                      input int mode, input int exp_cyc);
    int b0, s0, p0, dn0, cyc, nb;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h78; exp_b[1] = a; exp_b[2] = d;
    nb = nack_rel < 0 ? 3 : nack_rel + 1;
    b0 = ndec; s0 = nstart; p0 = nstop; dn0 = ndone;
    nack_at = nack_rel < 0 ? -1 : b0 + nack_rel;
    @(negedge clk);
    i2c_wen = 1'b1; reg_addr = a; reg_data = d;
    @(posedge clk);
    cyc = 0;
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      i2c_wen = mode == 1 ? busy && (cyc % 7 == 0) : 1'b0;
      if (mode == 1) begin reg_addr = 8'hFF; reg_data = 8'hFF; end
      if (mode == 2) begin reg_addr = 8'($urandom); reg_data = 8'($urandom); end
      if (cyc == 1) begin
        chk({tag, "_busy"}, 32'(busy), 1);
        chk({tag, "_errclr"}, 32'(ack_err), 0);
      end
      if (i2c_done) break;
    end
    i2c_wen = 1'b0;
    chk({tag, "_cyc"}, cyc, exp_cyc);
    chk({tag, "_ackerr"}, 32'(ack_err), nack_rel >= 0 ? 1 : 0);
    repeat (20) @(negedge clk);
    chk({tag, "_ndone"}, ndone - dn0, 1);
    chk({tag, "_nstart"}, nstart - s0, 1);
    chk({tag, "_nstop"}, nstop - p0, 1);
    chk({tag, "_nbytes"}, ndec - b0, nb);
    for (int i = 0; i < nb; i++) begin
      chk($sformatf("%s_byte%0d", tag, i), 32'(got_b[b0 + i]), 32'(exp_b[i]));
      chk($sformatf("%s_ack%0d", tag, i), 32'(got_a[b0 + i]), i == nack_rel ? 1 : 0);
    end
  endtask
  initial begin
    int bad, dn0, b0;
    logic hit;
    repeat (3) @(negedge clk);
    chk("rst_scl", 32'(scl), 1);
    chk("rst_sda_oe", 32'(sda_oe), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(i2c_done), 0);
    chk("rst_ackerr", 32'(ack_err), 0);
    rst_n = 1'b1;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (scl !== 1'b1 || sda_oe !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("idle_hold", bad, 0);
    xfer("ack_all", OLED_CTRL_CMD, 8'hB3, -1, 0, 465);
    xfer("nack1", OLED_CTRL_DATA, 8'h5C, 1, 0, 321);
    xfer("after_nack", OLED_CTRL_CMD, 8'hA5, -1, 0, 465);
    xfer("nack0", OLED_CTRL_CMD, 8'h01, 0, 0, 4 * (4 + 36 + 4) + 1);
    xfer("nack2", OLED_CTRL_DATA, 8'h0F, 2, 0, 465);
    xfer("junk_wen", OLED_CTRL_CMD, 8'h11, -1, 1, 465);
    xfer("churn", OLED_CTRL_DATA, 8'h6E, -1, 2, 465);
    dn0 = ndone; b0 = ndec; nack_at = -1;
    @(negedge clk);
    i2c_wen = 1'b1; reg_addr = OLED_CTRL_DATA; reg_data = 8'hC3;
    @(negedge clk);
    i2c_wen = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      hit = ndec == b0 + 2 && nbits == 5;
    end
    chk("rst_reach", 32'(hit), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_scl", 32'(scl), 1);
    chk("midrst_sda_oe", 32'(sda_oe), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(i2c_done), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_nodone", ndone - dn0, 0);
    xfer("post_rst", OLED_CTRL_CMD, 8'h3C, -1, 0, 465);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/oled_i2c_wr.md
# oled_i2c_wr

Single-master I2C write engine between the OLED display sequencer and the SSD1306 panel pins. Each accepted request is one register write of three bytes: slave address (write), control byte (`reg_addr`), data byte (`reg_data`). The engine serializes them onto SCL/SDA and returns a one-cycle `i2c_done` pulse. The sequencer drives `i2c_wen`/`reg_addr`/`reg_data` for one cycle only, so this block latches them on acceptance.

## Interface
- `CLK_DIV`, 125: clk cycles per quarter SCL period (125 gives 100 kHz SCL at 50 MHz); legal range 2..65535.
- `SLAVE_ADDR`, 8'h78: 8-bit slave address byte with R/W=0, sent first.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  synchronous, active-low reset
- `i2c_wen`  in  1  write request, sampled each cycle
- `reg_addr`  in  8  control byte (8'h00 command, 8'h40 data), latched with `i2c_wen`
- `reg_data`  in  8  payload byte, latched with `i2c_wen`
- `i2c_done`  out  1  one-cycle pulse when the transfer finishes, including NACK aborts
- `busy`  out  1  high from the cycle after acceptance through the `i2c_done` cycle, exclusive
- `ack_err`  out  1  sticky NACK flag; cleared when the next request is accepted
- `scl`  out  1  SCL, push-pull (single master, no clock stretching)
- `sda_oe`  out  1  1 = pull SDA low, 0 = release SDA (open-drain; the pad supplies the pull-up)
- `sda_i`  in  1  SDA pad input, already synchronized at the pad

## Operation
- Reset values: `scl`=1, `sda_oe`=0, `i2c_done`=0, `busy`=0, `ack_err`=0. State is IDLE, counters are 0.
- Quarter tick: a counter counts 0..CLK_DIV-1 while busy. A tick occurs at terminal count. Every phase step advances only on a tick.
- States:
  - IDLE: on `i2c_wen`, latch the bytes, clear `ack_err`, go to START.
  - START: 4 quarters. q0 SDA released, SCL=1. q1 SDA low. q2 and q3 SDA low, SCL=0 from q3.
  - BIT: 9 bits per byte (8 data MSB-first, then ACK). Each bit takes 4 quarters:
    - q0: SCL=0, SDA updated (data bit, or released for ACK).
    - q1: SCL=0.
    - q2: SCL=1.
    - q3: SCL=1.
    - `sda_i` is sampled on the tick ending q2.
    - Byte index runs 0 (SLAVE_ADDR), 1 (reg_addr), 2 (reg_data).
  - ACK check: if the sampled ACK bit is 1, set `ack_err` and go to STOP. Otherwise advance to the next byte, or to STOP after byte 2.
  - STOP: 4 quarters. q0 SCL=0 with SDA low. q1 SCL=1. q2 SDA released. q3 idle-high.
  - DONE: `i2c_done`=1 for one cycle, then IDLE.
- Data bit 1 is sent as `sda_oe`=0; data bit 0 as `sda_oe`=1.
- `i2c_wen` while busy, or in the DONE cycle, is ignored with no side effect.
- Reset mid-transfer: return to IDLE with the bus released on the next edge. No bus-recovery clocking is done.

## Timing
- Full transfer: START 4 + 27 bits × 4 + STOP 4 = 116 quarters. `i2c_done` rises 116·CLK_DIV+1 cycles after the `i2c_wen` sample cycle.
- NACK on byte n (0..2): START 4 + (n+1)·36 + STOP 4 quarters, then the DONE cycle.
- Earliest next acceptance: the cycle after `i2c_done`. The sequencer's own guard delay covers this.
- Latched bytes are stable for the whole transfer. Input changes after acceptance have no effect.
- SCL high and low each last 2·CLK_DIV cycles. SDA changes only while SCL=0, except the START and STOP edges.

## Structure
- Shared package `oled_pkg` holds:
  - SSD1306 constants: `OLED_SLAVE_ADDR`=8'h78, `OLED_CTRL_CMD`=8'h00, `OLED_CTRL_DATA`=8'h40.
  - The state enum (IDLE, START, BIT, STOP, DONE).
  - `OLED_XFER_QUARTERS`=116.
- One sub-module, `i2c_quarter_tick`: parameterized divider with inputs `clk`, `rst_n`, `run` and output `tick`. Its count restarts at 0 whenever `run` is low.
- The bit/quarter/byte counters and shift register stay in the top module.

## Test plan
- Reset, then hold idle: `scl`=1, `sda_oe`=0, `busy`=0 for 1000 cycles.
- CLK_DIV=4, `i2c_wen` with 8'h00/8'hB3, slave model ACKs every byte:
  - Decoded bus is START, 78 A, 00 A, B3 A, STOP.
  - `i2c_done` appears exactly 465 cycles after the wen cycle, `ack_err`=0.
- Slave NACKs byte 1 (8'h40):
  - Bus is START, 78 A, 40 N, STOP, with no data byte.
  - `ack_err`=1 and `i2c_done` arrives 4·(4+72+4)+1 = 321 cycles after wen.
  - The next request clears `ack_err`.
- Extra `i2c_wen` pulses mid-transfer with 8'hFF/8'hFF: the bus shows only the first request's bytes, and only one `i2c_done` occurs.
- Inputs change every cycle after acceptance: the transmitted bytes equal the values present in the wen cycle.
- Reset asserted during bit 5 of byte 2: next cycle `scl`=1, `sda_oe`=0, `busy`=0, with no `i2c_done`. A following request then completes normally.
